ddr_frame_writer: RTL

//  Parametrised MCB write-port master: streams pixel words from the fractal engine into DDR as

---
 rtl/ddr_frame_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: streams pixel words into DDR as write bursts on one MIG user port,
// ping-ponging between two frame buffers so the reader always scans a finished frame.
`default_nettype none

module ddr_frame_writer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 30,
    parameter int                    BURST_LEN   = 16,
    parameter int                    FRAME_WORDS = 307200,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_0 = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_1 = 'h12C000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    calib_done,
    input  logic                    frame_start,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic                    p_wr_full,
    input  logic                    p_cmd_full,
    output logic                    p_wr_en,
    output logic [DATA_WIDTH-1:0]   p_wr_data,
    output logic [DATA_WIDTH/8-1:0] p_wr_mask,
    output logic                    p_cmd_en,
    output logic [2:0]              p_cmd_instr,
    output logic [5:0]              p_cmd_bl,
    output logic [ADDR_WIDTH-1:0]   p_cmd_byte_addr,
    output logic                    mem_rst,
    output logic                    display_sel,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    start_overrun
);

    localparam int          BSHIFT     = $clog2(DATA_WIDTH / 8);
    localparam int          PTR_W      = $clog2(FRAME_WORDS + 1);
    localparam logic [31:0] FW         = 32'(FRAME_WORDS);
    localparam logic [31:0] BL         = 32'(BURST_LEN);
    localparam logic [6:0]  FIRST_BLEN = (BURST_LEN < FRAME_WORDS) ? 7'(BURST_LEN) : 7'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_FILL = 3'd2,
        S_CMD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic             calib_meta, calib_sync;
    logic [PTR_W-1:0] word_ptr;
    logic [6:0]       bcnt, blen, blen_after;
    logic [PTR_W:0]   ptr_after;
    logic [31:0]      remain;
    logic             wr_buf;
    logic             accept;

    assign ptr_after  = {1'b0, word_ptr} + (PTR_W+1)'(blen);
    assign remain     = FW - 32'(ptr_after);
    assign blen_after = (remain < BL) ? 7'(remain) : 7'(BURST_LEN);
    assign accept     = src_valid && src_ready;

    assign p_wr_mask       = '0;
    assign p_cmd_instr     = 3'b000;
    assign p_cmd_bl        = 6'(blen - 7'd1);
    assign p_cmd_byte_addr = (wr_buf ? BASE_ADDR_1 : BASE_ADDR_0) + (ADDR_WIDTH'(word_ptr) << BSHIFT);
    assign display_sel     = ~wr_buf;
    assign busy            = (state == S_FILL) || (state == S_CMD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= calib_done;
            calib_sync <= calib_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nx;
    end

    // FILL hands over to CMD only once the last beat is registered, so the
    // command always trails the final write-FIFO push by at least one cycle.
    always_comb begin
        state_nx   = state;
        src_ready  = 1'b0;
        p_cmd_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_INIT: if (calib_sync) state_nx = S_IDLE;
            S_IDLE: if (frame_start) state_nx = S_FILL;
            S_FILL: begin
                src_ready = !p_wr_full && (bcnt < blen);
                if (bcnt == blen) state_nx = S_CMD;
            end
            S_CMD: begin
                if (!p_cmd_full) begin
                    p_cmd_en = 1'b1;
                    state_nx = (32'(ptr_after) < FW) ? S_FILL : S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_ptr      <= '0;
            bcnt          <= '0;
            blen          <= '0;
            wr_buf        <= 1'b0;
            p_wr_en       <= 1'b0;
            p_wr_data     <= '0;
            mem_rst       <= 1'b1;
            start_overrun <= 1'b0;
        end else begin
            mem_rst <= 1'b0;
            p_wr_en <= accept;
            if (accept) begin
                p_wr_data <= src_data;
                bcnt      <= bcnt + 7'd1;
            end
            if (state == S_IDLE && frame_start) begin
                word_ptr <= '0;
                bcnt     <= '0;
                blen     <= FIRST_BLEN;
            end
            if (p_cmd_en) begin
                word_ptr <= ptr_after[PTR_W-1:0];
                bcnt     <= '0;
                blen     <= blen_after;
            end
            if (state == S_DONE) wr_buf <= ~wr_buf;
            if (frame_start && state != S_IDLE && state != S_INIT) start_overrun <= 1'b1;
        end
    end

endmodule

`default_nettype wire
